// File: rtl/fano_sync_pkg.sv
// Shared types and helpers for the Fano sync search/lock controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fano_sync_pkg;

   typedef enum logic [1:0] {
      SEARCH   = 2'd0,
      CONFIRM  = 2'd1,
      LOCKED   = 2'd2,
      FLYWHEEL = 2'd3
   } sync_state_t;

   localparam int SAT_W = 64;

   // Add a -1/0/+1 step to a signed value, clamping to the range of a
   // signed w-bit register (w must be below SAT_W).
   function automatic logic signed [SAT_W-1:0] sat_add(
      input logic signed [SAT_W-1:0] a,
      input logic signed [1:0]       d,
      input int                      w
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      logic signed [SAT_W-1:0] s;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      s  = a + SAT_W'(d);
      if (s > hi)
         sat_add = hi;
      else if (s < lo)
         sat_add = lo;
      else
         sat_add = s;
   endfunction

endpackage

// File: rtl/fano_sync_window.sv
// Evaluation window: counts symbols, accumulates saturating net threshold metric, judges good/bad.
// Latency: eval/good registered, high the cycle after the symbol that closes the window.
// Backpressure: none; every input cycle is consumed.
module fano_sync_window
   import fano_sync_pkg::*;
#(
   parameter int PERIOD_W = 24,
   parameter int THR_W    = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                vld,
   input  logic                t_up,
   input  logic                t_down,
   input  logic [PERIOD_W-1:0] sync_period,
   input  logic [THR_W-1:0]    sync_threshold,
   output logic                eval,
   output logic                good
);

   localparam int MW = PERIOD_W + 1;
   localparam int CW = (MW > THR_W + 1) ? MW : THR_W + 1;

   logic [PERIOD_W-1:0]  sym_cnt;
   logic signed [MW-1:0] metric;
   logic signed [MW-1:0] metric_nxt;
   logic signed [1:0]    delta;
   logic [PERIOD_W:0]    period_eff;
   logic [PERIOD_W:0]    cnt_inc;
   logic                 win_end;
   logic signed [CW-1:0] metric_ext;
   logic signed [CW-1:0] thr_ext;

   // Net threshold movement this cycle and whether this symbol closes the window.
   always_comb begin
      delta = 2'sd0;
      if (t_up && !t_down)
         delta = 2'sd1;
      else if (t_down && !t_up)
         delta = -2'sd1;
      metric_nxt = MW'(sat_add(SAT_W'(metric), delta, MW));
      // A zero period behaves as a one-symbol window.
      period_eff = (sync_period == '0) ? (PERIOD_W+1)'(1) : {1'b0, sync_period};
      // One bit wider so the count can never wrap; a shrunk period ends on the next symbol.
      cnt_inc    = {1'b0, sym_cnt} + (PERIOD_W+1)'(1);
      win_end    = vld && (cnt_inc >= period_eff);
      metric_ext = CW'(metric_nxt);
      thr_ext    = CW'($signed({1'b0, sync_threshold}));
   end

   // Accumulate the window; on its last symbol register the verdict and clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sym_cnt <= '0;
         metric  <= '0;
         eval    <= 1'b0;
         good    <= 1'b0;
      end else begin
         eval <= win_end;
         good <= win_end && (metric_ext > thr_ext);
         if (win_end) begin
            sym_cnt <= '0;
            metric  <= '0;
         end else begin
            metric <= metric_nxt;
            if (vld)
               sym_cnt <= cnt_inc[PERIOD_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fano_sync_ctrl.sv
// Fano sync search/lock controller: hysteretic lock FSM stepping LLR phase and deperforator hypotheses.
// Latency: FSM acts on the eval cycle; all outputs registered, one cycle after eval.
// Backpressure: none; evaluation runs continuously on the symbol stream.
module fano_sync_ctrl
   import fano_sync_pkg::*;
#(
   parameter int PERIOD_W   = 24,
   parameter int THR_W      = 16,
   parameter int N_PHASES   = 4,
   parameter int N_DEPERF   = 2,
   parameter int LOCK_CNT   = 2,
   parameter int UNLOCK_CNT = 3,
   localparam int PH_W = (N_PHASES > 1) ? $clog2(N_PHASES) : 1,
   localparam int DP_W = (N_DEPERF > 1) ? $clog2(N_DEPERF) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_vld,
   input  logic                i_T_up,
   input  logic                i_T_down,
   input  logic [PERIOD_W-1:0] i_sync_period,
   input  logic [THR_W-1:0]    i_sync_threshold,
   output logic                o_llr_reset,
   output logic                o_next_phase,
   output logic                o_deperf_next_st,
   output logic [PH_W-1:0]     o_phase_idx,
   output logic [DP_W-1:0]     o_deperf_idx,
   output logic                o_search_wrap,
   output logic                o_is_sync,
   output logic                o_sync_lost
);

   localparam int GC_W = $clog2(LOCK_CNT + 1);
   localparam int BC_W = $clog2(UNLOCK_CNT + 1);

   logic            eval;
   logic            good;
   sync_state_t     state;
   logic [GC_W-1:0] good_cnt;
   logic [BC_W-1:0] bad_cnt;
   logic            phase_last;
   logic            deperf_last;
   logic [PH_W-1:0] phase_step;
   logic [DP_W-1:0] deperf_step;
   logic            do_step;
   logic            lose;

   fano_sync_window #(
      .PERIOD_W (PERIOD_W),
      .THR_W    (THR_W)
   ) u_window (
      .clk            (clk),
      .reset_n        (reset_n),
      .vld            (i_vld),
      .t_up           (i_T_up),
      .t_down         (i_T_down),
      .sync_period    (i_sync_period),
      .sync_threshold (i_sync_threshold),
      .eval           (eval),
      .good           (good)
   );

   // Next hypothesis indices and which kind of transition this eval triggers.
   always_comb begin
      phase_last  = (o_phase_idx == PH_W'(N_PHASES - 1));
      deperf_last = (o_deperf_idx == DP_W'(N_DEPERF - 1));
      phase_step  = phase_last ? '0 : o_phase_idx + PH_W'(1);
      deperf_step = deperf_last ? '0 : o_deperf_idx + DP_W'(1);
      // A bad window while hunting moves to the next hypothesis.
      do_step     = eval && !good && (state == SEARCH || state == CONFIRM);
      // Enough bad windows while locked abandon the lock entirely.
      lose        = eval && !good &&
                    ((state == LOCKED && UNLOCK_CNT == 1) ||
                     (state == FLYWHEEL && bad_cnt == BC_W'(UNLOCK_CNT - 1)));
   end

   // Lock FSM, hypothesis counters and single-cycle pulse outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state            <= SEARCH;
         good_cnt         <= '0;
         bad_cnt          <= '0;
         o_llr_reset      <= 1'b0;
         o_next_phase     <= 1'b0;
         o_deperf_next_st <= 1'b0;
         o_phase_idx      <= '0;
         o_deperf_idx     <= '0;
         o_search_wrap    <= 1'b0;
         o_is_sync        <= 1'b0;
         o_sync_lost      <= 1'b0;
      end else begin
         o_llr_reset      <= 1'b0;
         o_next_phase     <= 1'b0;
         o_deperf_next_st <= 1'b0;
         o_search_wrap    <= 1'b0;
         o_sync_lost      <= 1'b0;
         if (eval) begin
            case (state)
               SEARCH: begin
                  if (good) begin
                     if (LOCK_CNT == 1) begin
                        state     <= LOCKED;
                        o_is_sync <= 1'b1;
                     end else begin
                        state    <= CONFIRM;
                        good_cnt <= GC_W'(1);
                     end
                  end
               end
               CONFIRM: begin
                  if (good) begin
                     if (good_cnt == GC_W'(LOCK_CNT - 1)) begin
                        state     <= LOCKED;
                        o_is_sync <= 1'b1;
                        good_cnt  <= '0;
                     end else begin
                        good_cnt <= good_cnt + GC_W'(1);
                     end
                  end else begin
                     state    <= SEARCH;
                     good_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (!good) begin
                     state   <= FLYWHEEL;
                     bad_cnt <= BC_W'(1);
                  end
               end
               FLYWHEEL: begin
                  if (good) begin
                     state   <= LOCKED;
                     bad_cnt <= '0;
                  end else begin
                     bad_cnt <= bad_cnt + BC_W'(1);
                  end
               end
               default: state <= SEARCH;
            endcase
         end
         if (do_step) begin
            o_next_phase <= 1'b1;
            o_phase_idx  <= phase_step;
            if (phase_last) begin
               o_deperf_next_st <= 1'b1;
               o_deperf_idx     <= deperf_step;
               if (deperf_last)
                  o_search_wrap <= 1'b1;
            end
         end
         // Loss of lock overrides the flywheel bookkeeping above.
         if (lose) begin
            state        <= SEARCH;
            bad_cnt      <= '0;
            o_is_sync    <= 1'b0;
            o_sync_lost  <= 1'b1;
            o_llr_reset  <= 1'b1;
            o_phase_idx  <= '0;
            o_deperf_idx <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fano_sync_ctrl.sv
// Directed bench for fano_sync_ctrl with a per-cycle behavioural model.
// Latency: model predicts registered outputs after each rising edge.
// Backpressure: n/a.
module tb_fano_sync_ctrl;

   localparam int PW  = 4;
   localparam int TW  = 16;
   localparam int NP  = 4;
   localparam int ND  = 2;
   localparam int LC  = 2;
   localparam int UC  = 3;
   localparam int PHW = (NP > 1) ? $clog2(NP) : 1;
   localparam int DPW = (ND > 1) ? $clog2(ND) : 1;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           i_vld;
   logic           i_T_up;
   logic           i_T_down;
   logic [PW-1:0]  i_sync_period;
   logic [TW-1:0]  i_sync_threshold;
   logic           o_llr_reset;
   logic           o_next_phase;
   logic           o_deperf_next_st;
   logic [PHW-1:0] o_phase_idx;
   logic [DPW-1:0] o_deperf_idx;
   logic           o_search_wrap;
   logic           o_is_sync;
   logic           o_sync_lost;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk   = 1'b0;

   always #5 clk = ~clk;

   fano_sync_ctrl #(
      .PERIOD_W   (PW),
      .THR_W      (TW),
      .N_PHASES   (NP),
      .N_DEPERF   (ND),
      .LOCK_CNT   (LC),
      .UNLOCK_CNT (UC)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_vld            (i_vld),
      .i_T_up           (i_T_up),
      .i_T_down         (i_T_down),
      .i_sync_period    (i_sync_period),
      .i_sync_threshold (i_sync_threshold),
      .o_llr_reset      (o_llr_reset),
      .o_next_phase     (o_next_phase),
      .o_deperf_next_st (o_deperf_next_st),
      .o_phase_idx      (o_phase_idx),
      .o_deperf_idx     (o_deperf_idx),
      .o_search_wrap    (o_search_wrap),
      .o_is_sync        (o_is_sync),
      .o_sync_lost      (o_sync_lost)
   );

   // Behavioural model: hypothesis is one integer 0..NP*ND-1, lock is a flag plus a streak count.
   int m_metric = 0;
   int m_cnt    = 0;
   int m_hyp    = 0;
   int m_streak = 0;
   bit m_locked = 1'b0;
   bit m_pend   = 1'b0;
   bit m_pgood  = 1'b0;
   bit e_np, e_dn, e_wrap, e_lost, e_llr;

   always @(posedge clk) begin
      int per;
      e_np = 1'b0; e_dn = 1'b0; e_wrap = 1'b0; e_lost = 1'b0; e_llr = 1'b0;
      if (!reset_n) begin
         m_metric = 0; m_cnt = 0; m_hyp = 0; m_streak = 0;
         m_locked = 1'b0; m_pend = 1'b0; m_pgood = 1'b0;
      end else begin
         if (m_pend) begin
            if (!m_locked) begin
               if (m_pgood) begin
                  m_streak++;
                  if (m_streak >= LC) begin m_locked = 1'b1; m_streak = 0; end
               end else begin
                  m_streak = 0;
                  e_np = 1'b1;
                  if (m_hyp % NP == NP - 1) e_dn = 1'b1;
                  if (m_hyp == NP * ND - 1) e_wrap = 1'b1;
                  m_hyp = (m_hyp + 1) % (NP * ND);
               end
            end else begin
               if (m_pgood) m_streak = 0;
               else begin
                  m_streak++;
                  if (m_streak >= UC) begin
                     m_locked = 1'b0; m_streak = 0; m_hyp = 0;
                     e_lost = 1'b1; e_llr = 1'b1;
                  end
               end
            end
         end
         m_pend = 1'b0;
         if (i_T_up && !i_T_down) m_metric++;
         else if (i_T_down && !i_T_up) m_metric--;
         if (m_metric > (1 << PW) - 1) m_metric = (1 << PW) - 1;
         if (m_metric < -(1 << PW)) m_metric = -(1 << PW);
         if (i_vld) begin
            m_cnt++;
            per = (i_sync_period == 0) ? 1 : int'(i_sync_period);
            if (m_cnt >= per) begin
               m_pend  = 1'b1;
               m_pgood = (m_metric > int'(i_sync_threshold));
               m_metric = 0; m_cnt = 0;
            end
         end
      end
   end

   // Every cycle: all DUT outputs against the model.
   always @(negedge clk) begin
      if (chk) begin
         n_cmp++;
         if ({o_llr_reset, o_next_phase, o_deperf_next_st, o_search_wrap, o_is_sync, o_sync_lost} !==
             {e_llr, e_np, e_dn, e_wrap, m_locked, e_lost} ||
             o_phase_idx !== PHW'(m_hyp % NP) || o_deperf_idx !== DPW'(m_hyp / NP)) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t got llr/np/dn/wrap/sync/lost=%b%b%b%b%b%b ph=%0d dp=%0d want %b%b%b%b%b%b ph=%0d dp=%0d",
                     $time, o_llr_reset, o_next_phase, o_deperf_next_st, o_search_wrap, o_is_sync, o_sync_lost,
                     o_phase_idx, o_deperf_idx, e_llr, e_np, e_dn, e_wrap, m_locked, e_lost, m_hyp % NP, m_hyp / NP);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0d want %0d", name, got, exp);
      end
   endtask

   task automatic cyc(input bit v, input bit u, input bit d);
      i_vld = v; i_T_up = u; i_T_down = d;
      @(negedge clk);
   endtask

   // n symbols; ups on the first nu, downs on the first nd; then one idle cycle.
   task automatic run_window(input int n, input int nu, input int nd);
      for (int i = 0; i < n; i++) cyc(1'b1, i < nu, i < nd);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0; i_vld = 1'b0; i_T_up = 1'b0; i_T_down = 1'b0;
      i_sync_period = 4'd2; i_sync_threshold = 16'd2;
      @(negedge clk);
      chk = 1'b1;
      check("rst_is_sync", o_is_sync, 0);
      check("rst_phase", o_phase_idx, 0);
      check("rst_deperf", o_deperf_idx, 0);
      check("rst_next_phase", o_next_phase, 0);
      reset_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);

      // Search sweep with no ups: every eval steps the hypothesis.
      for (int w = 1; w <= 8; w++) begin
         run_window(2, 0, 0);
         check("sweep_next_phase", o_next_phase, 1);
         if (w == 4) begin
            check("sweep4_deperf_next", o_deperf_next_st, 1);
            check("sweep4_deperf_idx", o_deperf_idx, 1);
            check("sweep4_phase_idx", o_phase_idx, 0);
         end
         if (w == 8) begin
            check("sweep8_wrap", o_search_wrap, 1);
            check("sweep8_phase_idx", o_phase_idx, 0);
            check("sweep8_deperf_idx", o_deperf_idx, 0);
         end
      end
      run_window(2, 0, 0);
      run_window(2, 0, 0);
      check("pre_lock_phase", o_phase_idx, 2);

      // Lock: period 8, threshold 2, 5 ups per window.
      i_sync_period = 4'd8;
      run_window(8, 5, 0);
      check("confirm_no_sync", o_is_sync, 0);
      check("confirm_no_step", o_next_phase, 0);
      for (int i = 0; i < 8; i++) cyc(1'b1, i < 5, 1'b0);
      check("sync_at_eval", o_is_sync, 0);
      cyc(1'b0, 1'b0, 1'b0);
      check("sync_after_eval", o_is_sync, 1);
      check("lock_phase_kept", o_phase_idx, 2);

      // Flywheel: 2 bad + 1 good holds lock; then 3 bad loses it.
      run_window(8, 0, 0);
      run_window(8, 0, 0);
      run_window(8, 5, 0);
      check("flywheel_hold", o_is_sync, 1);
      for (int k = 0; k < 3; k++) run_window(8, 0, 0);
      check("lost_pulse", o_sync_lost, 1);
      check("lost_llr_reset", o_llr_reset, 1);
      check("lost_phase", o_phase_idx, 0);
      check("lost_sync", o_is_sync, 0);
      check("lost_no_step", o_next_phase, 0);

      // Up and down together cancel; threshold 0 makes the window bad.
      i_sync_threshold = 16'd0; i_sync_period = 4'd4;
      run_window(4, 4, 4);
      check("both_bad_step", o_next_phase, 1);
      check("both_phase", o_phase_idx, 1);

      // Period 0: every symbol is an eval.
      i_sync_threshold = 16'd2; i_sync_period = 4'd0;
      cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("p0_phase", o_phase_idx, 0);
      check("p0_deperf", o_deperf_idx, 1);

      // Period shrunk below the current count: next symbol closes the window.
      i_sync_period = 4'd8;
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
      check("shrink_no_eval_yet", o_next_phase, 0);
      i_sync_period = 4'd3;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("shrink_step", o_next_phase, 1);
      check("shrink_phase", o_phase_idx, 1);

      // Saturation at the low end: -20 clamps to -16, +17 leaves +1 > 0.
      i_sync_threshold = 16'd0; i_sync_period = 4'd1;
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b0);
      run_window(1, 0, 0);
      check("sat_lo_good", o_next_phase, 0);
      // High end: +20 clamps to +15, -17 leaves -2, bad from CONFIRM steps.
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b1);
      run_window(1, 0, 0);
      check("sat_hi_bad", o_next_phase, 1);
      check("sat_hi_phase", o_phase_idx, 2);

      // Reset mid-CONFIRM and mid-window.
      i_sync_threshold = 16'd2; i_sync_period = 4'd4;
      run_window(4, 4, 0);
      check("pre_rst_confirm", o_next_phase, 0);
      cyc(1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
      reset_n = 1'b0;
      cyc(1'b1, 1'b1, 1'b0);
      reset_n = 1'b1;
      check("midrst_phase", o_phase_idx, 0);
      check("midrst_deperf", o_deperf_idx, 0);
      check("midrst_sync", o_is_sync, 0);
      check("midrst_step", o_next_phase, 0);
      run_window(4, 2, 0);
      check("post_rst_step", o_next_phase, 1);
      check("post_rst_phase", o_phase_idx, 1);

      cyc(1'b0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
